// File: rtl/decoder_pkg.sv
// Shared constants, state type and helper functions for the index-to-mask
// decoder with group accumulation.
package decoder_pkg;

   localparam int IN_W  = 5;
   localparam int OUT_W = 32;
   localparam int CNT_W = 6;

   typedef enum logic {
      IDLE  = 1'b0,
      ACCUM = 1'b1
   } state_t;

   function automatic logic [OUT_W-1:0] onehot(input logic [IN_W-1:0] idx);
      return OUT_W'(1) << idx;
   endfunction

   // Behavioural reference count, useful for assertions and quick models.
   function automatic logic [CNT_W-1:0] popcount32(input logic [31:0] vec);
      logic [CNT_W-1:0] c;
      c = '0;
      for (int i = 0; i < 32; i++) c += CNT_W'(vec[i]);
      return c;
   endfunction

endpackage

// File: rtl/popcount32.sv
// Combinational 32-to-6 population count built as a balanced adder tree.
module popcount32 (
   input  logic [31:0] vec,
   output logic [5:0]  count
);

   logic [1:0] s1 [16];
   logic [2:0] s2 [8];
   logic [3:0] s3 [4];
   logic [4:0] s4 [2];

   // NOTE: every variable driven here is fully assigned on every pass, so no latch is inferred.
   always_comb begin
      for (int i = 0; i < 16; i++) s1[i] = {1'b0, vec[2*i]} + {1'b0, vec[2*i+1]};
      for (int i = 0; i < 8; i++)  s2[i] = {1'b0, s1[2*i]} + {1'b0, s1[2*i+1]};
      for (int i = 0; i < 4; i++)  s3[i] = {1'b0, s2[2*i]} + {1'b0, s2[2*i+1]};
      for (int i = 0; i < 2; i++)  s4[i] = {1'b0, s3[2*i]} + {1'b0, s3[2*i+1]};
      count = {1'b0, s4[0]} + {1'b0, s4[1]};
   end

endmodule

// File: rtl/decoder5x32_accum.sv
// Decodes a stream of register indices into a one-hot OR mask per group and
// presents the finished mask, its popcount and a duplicate flag on a registered valid/ready port.
module decoder5x32_accum
   import decoder_pkg::*;
#(
   parameter int IN_W  = 5,
   parameter int OUT_W = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  in_index,
   input  logic             in_last,
   input  logic             in_flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_mask,
   output logic [CNT_W-1:0] out_count,
   output logic             out_dup
);

   if (OUT_W != (2 ** IN_W) || CNT_W != IN_W + 1 || IN_W != 5) begin : g_bad_params
      $error("decoder5x32_accum: OUT_W must be 2**IN_W and CNT_W must be IN_W+1 with IN_W=5");
   end

   state_t           state, state_next;
   logic [OUT_W-1:0] acc, acc_next;
   logic             dup_acc, dup_next;
   logic [CNT_W-1:0] cnt_next;
   logic             beat, load;

   // Input only stalls while a finished mask sits unconsumed.
   assign in_ready = !(out_valid && !out_ready);
   // A flush wins over a same-cycle beat and drops it.
   assign beat     = in_valid && in_ready && !in_flush;
   assign load     = beat && in_last;

   always_comb begin
      acc_next   = acc | onehot(in_index);
      dup_next   = dup_acc | acc[in_index];
      state_next = state;
      if (in_flush)  state_next = IDLE;
      else if (beat) state_next = in_last ? IDLE : ACCUM;
   end

   popcount32 u_popcount (
      .vec   (acc_next),
      .count (cnt_next)
   );

   // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         acc     <= '0;
         dup_acc <= 1'b0;
      end else begin
         state <= state_next;
         if (in_flush || load) begin
            acc     <= '0;
            dup_acc <= 1'b0;
         end else if (beat) begin
            acc     <= acc_next;
            dup_acc <= dup_next;
         end
      end
   end

   // Output stage: a new group reloads even while the old one is being taken.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_mask  <= '0;
         out_count <= '0;
         out_dup   <= 1'b0;
      end else if (load) begin
         out_valid <= 1'b1;
         out_mask  <= acc_next;
         out_count <= cnt_next;
         out_dup   <= dup_next;
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_decoder5x32_accum.sv
// Self-checking bench: directed group scenarios with literal expectations plus
// randomized traffic compared every cycle against an occurrence-count model.
module tb_decoder5x32_accum;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [4:0]  in_index = '0;
   logic        in_last = 1'b0;
   logic        in_flush = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] out_mask;
   logic [5:0]  out_count;
   logic        out_dup;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   decoder5x32_accum dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_index  (in_index),
      .in_last   (in_last),
      .in_flush  (in_flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_mask  (out_mask),
      .out_count (out_count),
      .out_dup   (out_dup)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model: count how often each register index appeared in the open group.
   int          occ [32];
   bit          m_valid;
   logic [31:0] m_mask;
   logic [5:0]  m_cnt;
   bit          m_dup;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         foreach (occ[i]) occ[i] = 0;
         m_valid = 0; m_mask = '0; m_cnt = '0; m_dup = 0;
      end else begin
         bit rdy, take;
         rdy  = !(m_valid && !out_ready);
         take = in_valid && rdy && !in_flush;
         if (m_valid && out_ready) m_valid = 0;
         if (in_flush) begin
            foreach (occ[i]) occ[i] = 0;
         end else if (take) begin
            occ[in_index]++;
            if (in_last) begin
               m_mask = '0; m_cnt = '0; m_dup = 0;
               for (int i = 0; i < 32; i++) begin
                  if (occ[i] > 0) begin m_mask[i] = 1'b1; m_cnt++; end
                  if (occ[i] > 1) m_dup = 1;
               end
               m_valid = 1;
               foreach (occ[i]) occ[i] = 0;
            end
         end
      end
   end

   // Compare process, sampled mid-cycle.
   always @(negedge clk) begin
      if (rst_n) begin
         check("in_ready", 64'(in_ready), 64'(!(m_valid && !out_ready)));
         check("out_valid", 64'(out_valid), 64'(m_valid));
         if (m_valid) begin
            check("out_mask", 64'(out_mask), 64'(m_mask));
            check("out_count", 64'(out_count), 64'(m_cnt));
            check("out_dup", 64'(out_dup), 64'(m_dup));
         end
      end
   end

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic send(input int idx, input bit last, input bit flush = 1'b0);
      in_valid = 1'b1; in_index = 5'(idx); in_last = last; in_flush = flush;
      step();
      in_valid = 1'b0; in_last = 1'b0; in_flush = 1'b0;
   endtask

   task automatic pin(input string name, input logic [31:0] mask, input int cnt, input bit dup);
      check({name, "_valid"}, 64'(out_valid), 64'd1);
      check({name, "_mask"},  64'(out_mask),  64'(mask));
      check({name, "_count"}, 64'(out_count), 64'(cnt));
      check({name, "_dup"},   64'(out_dup),   64'(dup));
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      #12;
      check("rst_valid", 64'(out_valid), 64'd0);
      check("rst_mask",  64'(out_mask),  64'd0);
      check("rst_count", 64'(out_count), 64'd0);
      check("rst_dup",   64'(out_dup),   64'd0);
      check("rst_ready", 64'(in_ready),  64'd1);
      rst_n = 1'b1;
      step();

      send(5, 1);
      pin("single", 32'h0000_0020, 1, 0);
      step();
      check("single_drop", 64'(out_valid), 64'd0);

      send(0, 0); send(3, 0);
      check("three_early", 64'(out_valid), 64'd0);
      send(31, 1);
      pin("three", 32'h8000_0009, 3, 0);
      step();
      check("three_drop", 64'(out_valid), 64'd0);

      send(7, 0); send(7, 0); send(2, 1);
      pin("dup", 32'h0000_0084, 2, 1);
      step();

      for (int i = 0; i < 31; i++) send(i, 0);
      out_ready = 1'b0;
      send(31, 1);
      pin("all", 32'hFFFF_FFFF, 32, 0);
      check("all_stall", 64'(in_ready), 64'd0);
      repeat (3) step();
      pin("all_hold", 32'hFFFF_FFFF, 32, 0);
      check("all_stall2", 64'(in_ready), 64'd0);
      out_ready = 1'b1; #1;
      check("all_release", 64'(in_ready), 64'd1);
      step();
      check("all_drop", 64'(out_valid), 64'd0);

      send(4, 0); send(9, 0); send(12, 0, 1'b1); send(1, 1);
      pin("flush", 32'h0000_0002, 1, 0);
      step();

      send(0, 1); pin("b2b0", 32'h1, 1, 0);
      send(1, 1); pin("b2b1", 32'h2, 1, 0);
      send(2, 1); pin("b2b2", 32'h4, 1, 0);
      step();
      check("b2b_drop", 64'(out_valid), 64'd0);

      out_ready = 1'b0;
      send(10, 1);
      out_ready = 1'b1;
      send(11, 0); send(12, 0);
      #2 rst_n = 1'b0; #1;
      check("arst_valid", 64'(out_valid), 64'd0);
      check("arst_mask",  64'(out_mask),  64'd0);
      check("arst_count", 64'(out_count), 64'd0);
      step();
      rst_n = 1'b1;
      step();
      check("post_rst_valid", 64'(out_valid), 64'd0);
      send(3, 1);
      pin("post_rst", 32'h0000_0008, 1, 0);
      step();

      for (int c = 0; c < 3000; c++) begin
         in_valid  = ($urandom_range(0, 99) < 70);
         in_index  = 5'($urandom_range(0, 31));
         in_last   = ($urandom_range(0, 99) < 20);
         in_flush  = ($urandom_range(0, 99) < 4);
         out_ready = ($urandom_range(0, 99) < 70);
         step();
      end
      in_valid = 1'b0; in_last = 1'b0; in_flush = 1'b0; out_ready = 1'b1;
      repeat (3) step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
